// File: rtl/mealy_nonoverlap_pkg.sv
// Shared types and constants for the mealy_nonoverlap 1-0-1-1 detector.
package mealy_nonoverlap_pkg;

  // Detector states, named by the longest pattern prefix seen so far
  typedef enum logic [1:0] {
    S0 = 2'd0,  // idle, no prefix
    S1 = 2'd1,  // "1"
    S2 = 2'd2,  // "10"
    S3 = 2'd3   // "101"
  } state_t;

  // Pattern, most significant bit arrives first
  localparam logic [3:0] PATTERN = 4'b1011;

  // Width of the optional match counter
  localparam int CNT_W = 8;

endpackage

// File: rtl/mealy_nonoverlap_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Used by mealy_nonoverlap only when DETECT_COUNT_EN is defined.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q = '0;
  logic [W-1:0] cnt_d;

  // Next count: hold at all-ones once saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, clear has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mealy_nonoverlap.sv
// Non-overlapping Mealy detector for the serial pattern 1-0-1-1 (MSB first).
// dout is combinational from the current state and din.
// Optional feature macro: DETECT_COUNT_EN adds a saturating 8-bit match
// counter on port det_cnt.
module mealy_nonoverlap
  import mealy_nonoverlap_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic             dout
`ifdef DETECT_COUNT_EN
  ,
  output logic [CNT_W-1:0] det_cnt
`endif
);

  // Initializer lets the block start cleanly even without a reset edge
  state_t state_q = S0;
  state_t state_d;

  // State register; reset overrides din
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: keep the longest valid prefix, restart from S0 after a match
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = (din == PATTERN[3]) ? S1 : S0;
      // a repeated '1' is still a valid "1" prefix
      S1: state_d = (din == PATTERN[2]) ? S2 : S1;
      S2: state_d = (din == PATTERN[1]) ? S3 : S0;
      // match consumes every bit; "1010" keeps "10" as a prefix
      S3: state_d = (din == PATTERN[0]) ? S0 : S2;
      default: state_d = S0;
    endcase
  end

  // Mealy output: final pattern bit present while "101" has been seen
  always_comb begin
    dout = (state_q == S3) && (din == PATTERN[0]);
  end

`ifdef DETECT_COUNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .inc_i (dout),
    .cnt_o (det_cnt)
  );
`endif

endmodule

// File: tb/tb_mealy_nonoverlap.sv
// Directed testbench for mealy_nonoverlap. Inputs change at negedge,
// dout is sampled 1 ns later, well before the capturing posedge.
`timescale 1ns/1ps
module tb_mealy_nonoverlap;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic dout;
`ifdef DETECT_COUNT_EN
  logic [7:0] det_cnt;
  int exp_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  mealy_nonoverlap dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout)
`ifdef DETECT_COUNT_EN
    ,
    .det_cnt (det_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One bit per cycle: apply din/reset at negedge, check dout combinationally
  task automatic drive(input string tag, input logic b, input logic rst, input logic exp_dout);
    @(negedge clk);
`ifdef DETECT_COUNT_EN
    check({tag, "_cnt"}, int'(det_cnt), exp_cnt);
`endif
    din = b;
    reset = rst;
    #1;
    check({tag, "_dout"}, int'(dout), int'(exp_dout));
    $display("%0t %s din=%0b reset=%0b dout=%0b exp=%0b", $time, tag, b, rst, dout, exp_dout);
`ifdef DETECT_COUNT_EN
    if (rst) exp_cnt = 0;
    else if (exp_dout && exp_cnt < 255) exp_cnt++;
`endif
  endtask

  // First applied bit is bits[n-1]; exp carries the expected dout per bit
  task automatic drive_seq(input string tag, input logic [15:0] bits,
                           input logic [15:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive(tag, bits[i], 1'b0, exp[i]);
    end
  endtask

  // Two zeros return the FSM to S0 from any state
  task automatic flush();
    drive("flush", 1'b0, 1'b0, 1'b0);
    drive("flush", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset pulse with no clock edge; power-on state already S0
    reset = 1'b1;
    #2;
    reset = 1'b0;

    // Idle from reset: din=1 in S0 is not a match
    drive("reset_state", 1'b1, 1'b0, 1'b0);
    flush();

    // Three back-to-back matches after a leading 0
    drive_seq("triple", 16'b0101110111011, 16'b0000100010001, 13);

    // Non-overlap: trailing "011" must not reuse the matched '1'
    drive_seq("nonoverlap", 16'b1011011, 16'b0001000, 7);
    flush();

    // Prefix retention through repeated 1
    drive_seq("prefix_11011", 16'b11011, 16'b00001, 5);
    flush();

    // Prefix retention through S3 -> S2
    drive_seq("prefix_101011", 16'b101011, 16'b000001, 6);
    flush();

    // Negative case
    drive_seq("neg_10011", 16'b10011, 16'b00000, 5);
    flush();

    for (int i = 0; i < 20; i++) drive("all0", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive("all1", 1'b1, 1'b0, 1'b0);
    flush();

    // Reset mid-pattern discards progress
    drive_seq("mid_rst_pre", 16'b101, 16'b000, 3);
    drive("mid_rst", 1'b0, 1'b1, 1'b0);
    drive("mid_rst_post", 1'b1, 1'b0, 1'b0);
    drive_seq("mid_rst_resume", 16'b011, 16'b001, 3);

    // Reset during the 4th bit: dout still asserts, next state is S0
    drive_seq("rst4_pre", 16'b101, 16'b000, 3);
    drive("rst4_bit", 1'b1, 1'b1, 1'b1);
    drive("rst4_after", 1'b1, 1'b0, 1'b0);
    flush();

`ifdef DETECT_COUNT_EN
    // Saturation: clear, then 300 back-to-back matches
    drive("sat_clr", 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 300; g++) begin
      drive_seq("sat", 16'b1011, 16'b0001, 4);
    end
    @(negedge clk);
    #1;
    check("sat_final", int'(det_cnt), 255);
    drive("sat_rst", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("sat_cleared", int'(det_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mealy_nonoverlap.md
# mealy_nonoverlap

Serial bit-stream pattern detector built as a Mealy finite-state machine. It recognises the 4-bit sequence 1-0-1-1, most significant bit first, on a 1-bit input sampled once per clock. Detection is non-overlapping: after a match, no bit of the matched sequence is reused. It is a leaf block for any serial datapath that needs a combinational one-cycle match flag.

## Interface
- No parameters; pattern fixed at 4'b1011.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high; one clock, reset synchronous and active-high.
- din  input  1  serial data bit, sampled at each rising clk edge.
- dout  output  1  Mealy match flag, combinational from state and din.
- det_cnt  output  8  saturating match count; present only with DETECT_COUNT_EN (see Configuration).

## Operation
- States (2-bit encoding): S0=idle, S1="1", S2="10", S3="101".
- Transitions, written as din=0 / din=1:
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 / S0
- dout = 1 exactly when state==S3 and din==1; otherwise 0.
- Non-overlap rule: on a match, the next state is S0, not S1. The final '1' of a match never starts a new match.
- Within a partial match, the longest valid prefix is retained:
  - S1 with din=1 stays in S1.
  - S3 with din=0 goes to S2, because "1010" ends in "10".
- X or Z on din must not corrupt state in a way that reset cannot clear. Behaviour before the first reset edge is not guaranteed beyond the power-on rule below.

## Timing
- State register updates on posedge clk.
- reset=1 at a posedge forces state=S0. Reset has priority over din.
- Power-on: the state register carries a declaration initializer of S0. This lets the block run correctly even if reset deasserts before the first clock edge.
- dout has zero latency and is combinational:
  - It asserts in the same cycle the 4th pattern bit is present on din, before the capturing edge.
  - It drops when din or state changes.
- Reset mid-pattern discards progress. If reset is high during the 4th bit, dout still follows state and din combinationally, but the next state is S0.
- Minimum spacing between matches is 4 cycles.

## Configuration
- DETECT_COUNT_EN defined:
  - Adds port det_cnt[7:0], registered.
  - Increments at each posedge where dout==1 and reset==0.
  - Saturates at 255.
  - Cleared to 0 by reset; power-on initializer 0.
- DETECT_COUNT_EN undefined: the port and counter are absent. The port list is exactly clk, reset, din, dout, in that order.

## Structure
- Shared package mealy_nonoverlap_pkg holds:
  - state typedef: S0..S3 as a 2-bit enum.
  - PATTERN constant 4'b1011.
  - CNT_W constant 8.
- One natural sub-module: sat_counter, used only under DETECT_COUNT_EN.
- FSM next-state logic and output logic live in the top module.

## Test plan
- Reset pulse of 2 ns with no clock edge, then drive din = 0, 1,0,1,1, 1,0,1,1, 1,0,1,1 at negedges -> dout pulses exactly 3 times, each during the final '1' cycle. det_cnt=3 when enabled.
- Non-overlap: din=1,0,1,1,0,1,1 -> exactly one dout pulse, on bit 4. An overlapping detector would pulse on bit 7 as well; this block must not.
- Prefix retention: din=1,1,0,1,1 -> one pulse on bit 5. din=1,0,1,0,1,1 -> one pulse on bit 6, via the S3->S2 path.
- Negative case: din=1,0,0,1,1 -> no pulse. din all 0 or all 1 for 20 cycles -> dout stays 0.
- Reset mid-operation: drive 1,0,1, assert reset for one edge, then drive 1 -> no pulse. Then drive 0,1,1 -> pulse on the last bit.
- DETECT_COUNT_EN: drive 300 back-to-back "1011" groups -> det_cnt saturates at 255. A subsequent reset edge clears it to 0.
